// File: rtl/riscv_muldiv_pipe_if.sv
// Opcode-issue and writeback bundle for the RV32M multiply/divide unit.
// The issuing core drives the master side and the execution unit is the slave.
interface riscv_muldiv_pipe_if;
   logic        opcode_valid_i;
   logic [55:0] opcode_instr_i;
   logic [31:0] opcode_opcode_i;
   logic [31:0] opcode_pc_i;
   logic [4:0]  opcode_rd_idx_i;
   logic [4:0]  opcode_ra_idx_i;
   logic [4:0]  opcode_rb_idx_i;
   logic [31:0] opcode_ra_operand_i;
   logic [31:0] opcode_rb_operand_i;
   logic        flush_i;
   logic        writeback_valid_o;
   logic [4:0]  writeback_idx_o;
   logic [31:0] writeback_value_o;
   logic        writeback_squash_o;
   logic        stall_o;

   modport master (
      output opcode_valid_i, opcode_instr_i, opcode_opcode_i, opcode_pc_i, opcode_rd_idx_i,
             opcode_ra_idx_i, opcode_rb_idx_i, opcode_ra_operand_i, opcode_rb_operand_i, flush_i,
      input  writeback_valid_o, writeback_idx_o, writeback_value_o, writeback_squash_o, stall_o
   );

   modport slave (
      input  opcode_valid_i, opcode_instr_i, opcode_opcode_i, opcode_pc_i, opcode_rd_idx_i,
             opcode_ra_idx_i, opcode_rb_idx_i, opcode_ra_operand_i, opcode_rb_operand_i, flush_i,
      output writeback_valid_o, writeback_idx_o, writeback_value_o, writeback_squash_o, stall_o
   );
endinterface

// File: rtl/riscv_muldiv_pipe.sv
// RV32M execution unit: MUL_STAGES-deep pipelined multiplier, multi-bit restoring divider.
// Optional MULDIV_DIV_ZERO_FAST_EN retires divide-by-zero in one cycle without entering BUSY.
module riscv_muldiv_pipe #(
   parameter int unsigned MUL_STAGES         = 2,
   parameter int unsigned DIV_BITS_PER_CYCLE = 2
) (
   input logic                  clk_i,
   input logic                  rst_i,
   riscv_muldiv_pipe_if.slave   bus
);
   localparam int unsigned ENUM_INST_MUL    = 45;
   localparam int unsigned ENUM_INST_MULH   = 46;
   localparam int unsigned ENUM_INST_MULHSU = 47;
   localparam int unsigned ENUM_INST_MULHU  = 48;
   localparam int unsigned ENUM_INST_DIV    = 49;
   localparam int unsigned ENUM_INST_DIVU   = 50;
   localparam int unsigned ENUM_INST_REM    = 51;
   localparam int unsigned ENUM_INST_REMU   = 52;
   localparam logic [31:0] MaskInit = ~(32'hFFFF_FFFF >> DIV_BITS_PER_CYCLE);

   typedef enum logic [0:0] {StIdle, StBusy} div_state_e;

   logic [31:0] ra, rb;
   logic [4:0]  rd;
   logic        flush;
   logic        is_mul, is_mulh, is_mulhsu, is_mulhu, is_div, is_divu, is_rem, is_remu;
   logic        mul_op, div_op, stall, accept, mul_start, div_start, dz_fast;
   logic [31:0] dz_result;

   assign ra        = bus.opcode_ra_operand_i;
   assign rb        = bus.opcode_rb_operand_i;
   assign rd        = bus.opcode_rd_idx_i;
   assign flush     = bus.flush_i;
   assign is_mul    = bus.opcode_instr_i[ENUM_INST_MUL];
   assign is_mulh   = bus.opcode_instr_i[ENUM_INST_MULH];
   assign is_mulhsu = bus.opcode_instr_i[ENUM_INST_MULHSU];
   assign is_mulhu  = bus.opcode_instr_i[ENUM_INST_MULHU];
   assign is_div    = bus.opcode_instr_i[ENUM_INST_DIV];
   assign is_divu   = bus.opcode_instr_i[ENUM_INST_DIVU];
   assign is_rem    = bus.opcode_instr_i[ENUM_INST_REM];
   assign is_remu   = bus.opcode_instr_i[ENUM_INST_REMU];
   assign mul_op    = bus.opcode_valid_i & (is_mul | is_mulh | is_mulhsu | is_mulhu);
   assign div_op    = bus.opcode_valid_i & (is_div | is_divu | is_rem | is_remu);

   logic unused_ok;
   assign unused_ok = ^{bus.opcode_opcode_i, bus.opcode_pc_i, bus.opcode_ra_idx_i,
                        bus.opcode_rb_idx_i, bus.opcode_instr_i};

   // ---------------- multiplier ----------------
   logic signed [32:0]    mul_a, mul_b;
   logic signed [65:0]    mul_prod;
   logic [31:0]           mul_res;
   logic [MUL_STAGES-1:0] stg_valid_q;
   logic [4:0]            stg_rd_q  [MUL_STAGES];
   logic [31:0]           stg_res_q [MUL_STAGES];
   logic                  mul_inflight;

   assign mul_a        = {(is_mulh | is_mulhsu) & ra[31], ra};
   assign mul_b        = {is_mulh & rb[31], rb};
   assign mul_prod     = mul_a * mul_b;
   assign mul_res      = is_mul ? mul_prod[31:0] : mul_prod[63:32];
   assign mul_inflight = |stg_valid_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stg_valid_q <= '0;
         for (int i = 0; i < int'(MUL_STAGES); i++) begin
            stg_rd_q[i]  <= '0;
            stg_res_q[i] <= '0;
         end
      end else begin
         stg_valid_q[0] <= mul_start;
         stg_rd_q[0]    <= rd;
         stg_res_q[0]   <= mul_res;
         for (int i = 1; i < int'(MUL_STAGES); i++) begin
            stg_valid_q[i] <= stg_valid_q[i-1] & ~flush;
            stg_rd_q[i]    <= stg_rd_q[i-1];
            stg_res_q[i]   <= stg_res_q[i-1];
         end
      end
   end

   // ---------------- divider ----------------
   div_state_e  div_state_q, div_state_d;
   logic [31:0] dividend_q, dividend_d, quotient_q, quotient_d, q_mask_q, q_mask_d;
   logic [62:0] divisor_q, divisor_d;
   logic        div_inv_q, div_inv_d, div_rem_q, div_rem_d;
   logic [4:0]  div_rd_q, div_rd_d;
   logic [31:0] step_rem, step_quo, step_bit, ra_mag, rb_mag, div_mag, div_result;
   logic [62:0] step_dvs;
   logic        div_busy, div_done, div_signed;

   assign div_busy   = (div_state_q == StBusy);
   assign div_done   = div_busy & (q_mask_q == '0);
   assign div_signed = is_div | is_rem;
   assign ra_mag     = (div_signed & ra[31]) ? (~ra + 32'd1) : ra;
   assign rb_mag     = (div_signed & rb[31]) ? (~rb + 32'd1) : rb;
   assign div_mag    = div_rem_q ? dividend_q : quotient_q;
   assign div_result = div_inv_q ? (~div_mag + 32'd1) : div_mag;

   assign stall     = (div_busy & (mul_op | div_op)) | (mul_inflight & div_op);
   assign accept    = (mul_op | div_op) & ~stall & ~flush;
   assign mul_start = accept & mul_op;
   assign div_start = accept & div_op;

`ifdef MULDIV_DIV_ZERO_FAST_EN
   assign dz_fast   = div_start & (rb == '0);
   assign dz_result = (is_rem | is_remu) ? ra : 32'hFFFF_FFFF;
`else
   assign dz_fast   = 1'b0;
   assign dz_result = '0;
`endif

   // Each set bit of the mask group selects one restoring step, MSB first.
   always_comb begin
      step_rem = dividend_q;
      step_dvs = divisor_q;
      step_quo = quotient_q;
      step_bit = '0;
      for (int s = 0; s < int'(DIV_BITS_PER_CYCLE); s++) begin
         step_bit = (q_mask_q >> s) & ~(q_mask_q >> (s + 1));
         if (step_dvs <= {31'b0, step_rem}) begin
            step_rem = step_rem - step_dvs[31:0];
            step_quo = step_quo | step_bit;
         end
         step_dvs = step_dvs >> 1;
      end
   end

   always_comb begin
      div_state_d = div_state_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      q_mask_d    = q_mask_q;
      div_inv_d   = div_inv_q;
      div_rem_d   = div_rem_q;
      div_rd_d    = div_rd_q;
      unique case (div_state_q)
         StIdle: begin
            if (div_start & ~dz_fast) begin
               div_state_d = StBusy;
               dividend_d  = ra_mag;
               divisor_d   = {rb_mag, 31'b0};
               quotient_d  = '0;
               q_mask_d    = MaskInit;
               div_inv_d   = is_div ? ((ra[31] ^ rb[31]) & (rb != '0)) : (is_rem & ra[31]);
               div_rem_d   = is_rem | is_remu;
               div_rd_d    = rd;
            end
         end
         StBusy: begin
            if (flush || q_mask_q == '0) begin
               div_state_d = StIdle;
            end else begin
               dividend_d = step_rem;
               divisor_d  = step_dvs;
               quotient_d = step_quo;
               q_mask_d   = q_mask_q >> DIV_BITS_PER_CYCLE;
            end
         end
         default: div_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_state_q <= StIdle;
         dividend_q  <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         q_mask_q    <= '0;
         div_inv_q   <= 1'b0;
         div_rem_q   <= 1'b0;
         div_rd_q    <= '0;
      end else begin
         div_state_q <= div_state_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         q_mask_q    <= q_mask_d;
         div_inv_q   <= div_inv_d;
         div_rem_q   <= div_rem_d;
         div_rd_q    <= div_rd_d;
      end
   end

   // ---------------- writeback ----------------
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_idx_q, wb_idx_d;
   logic [31:0] wb_value_q, wb_value_d;

   // Stall rules keep these sources mutually exclusive on any given edge.
   always_comb begin
      wb_valid_d = 1'b0;
      wb_idx_d   = '0;
      wb_value_d = wb_value_q;
      if (!flush) begin
         if (stg_valid_q[MUL_STAGES-1]) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = stg_rd_q[MUL_STAGES-1];
            wb_value_d = stg_res_q[MUL_STAGES-1];
         end else if (div_done) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = div_rd_q;
            wb_value_d = div_result;
         end else if (dz_fast) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = rd;
            wb_value_d = dz_result;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_valid_q <= 1'b0;
         wb_idx_q   <= '0;
         wb_value_q <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_idx_q   <= wb_idx_d;
         wb_value_q <= wb_value_d;
      end
   end

   assign bus.writeback_valid_o  = wb_valid_q;
   assign bus.writeback_idx_o    = wb_idx_q;
   assign bus.writeback_value_o  = wb_value_q;
   assign bus.writeback_squash_o = 1'b0;
   assign bus.stall_o            = stall;
endmodule

// File: doc/riscv_muldiv_pipe.md
# riscv_muldiv_pipe

RV32M multiply/divide execution unit for the RISC-V core, issued from the same opcode bus as the ALU and writing back through the core's writeback port. It supersedes the fixed single-cycle-multiply / one-bit-per-cycle-divide unit with two additions: a configurable-depth pipelined multiplier and a divider that retires a configurable number of quotient bits per cycle. It also adds an explicit writeback valid and a pipeline flush.

## Interface
- `MUL_STAGES`, default 2: multiplier register stages, legal values 1..3. Multiplies are fully pipelined.
- `DIV_BITS_PER_CYCLE`, default 2: quotient bits produced per divider iteration, legal values 1, 2 or 4.
- `clk_i` input 1: core clock, the only clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `opcode_valid_i` input 1: the opcode bus carries an instruction this cycle.
- `opcode_instr_i` input 56: one-hot decode, indexed by `ENUM_INST_*` from `riscv_defs_pkg.sv`.
- `opcode_opcode_i` input 32: raw instruction. Unused.
- `opcode_pc_i` input 32: PC. Unused.
- `opcode_rd_idx_i` input 5: destination register.
- `opcode_ra_idx_i`, `opcode_rb_idx_i` input 5: source indices. Unused.
- `opcode_ra_operand_i`, `opcode_rb_operand_i` input 32: rs1 and rs2 values.
- `flush_i` input 1: discards every in-flight operation.
- `writeback_valid_o` output 1: writeback outputs carry a result this cycle.
- `writeback_idx_o` output 5: destination register; 0 when not valid.
- `writeback_value_o` output 32: result value; holds its last value when not valid.
- `writeback_squash_o` output 1: constant 0.
- `stall_o` output 1: the current opcode cannot be accepted.

## Operation
- An instruction is accepted when `opcode_valid_i & (mul_op | div_op) & !stall_o & !flush_i`.
  - `mul_op` is MUL, MULH, MULHSU or MULHU.
  - `div_op` is DIV, DIVU, REM or REMU.
- Multiplier operand extension:
  - MULH: both operands sign-extended to 33 bits.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MUL and MULHU: both unsigned.
  - The product is 66 bits. MUL returns bits [31:0]; the MULH* forms return bits [63:32].
- Multiplier pipeline: a `MUL_STAGES`-deep shift of {valid, rd, partial result}. The final stage feeds the writeback registers.
- Divider FSM has two states, IDLE and BUSY.
  - On start, rs1 and rs2 are captured as magnitudes when the operation is signed (DIV/REM) and the operand is negative.
  - The invert flag is set for DIV when the operand signs differ and rs2 != 0. It is set for REM when rs1 is negative.
  - The quotient mask is loaded with its top `DIV_BITS_PER_CYCLE` bits.
  - Each BUSY cycle performs `DIV_BITS_PER_CYCLE` unrolled restoring subtract/shift steps.
  - The FSM returns to IDLE after 32/`DIV_BITS_PER_CYCLE` iterations plus one completion cycle.
- Division results:
  - The result is the quotient for DIV/DIVU and the remainder for REM/REMU, two's-complement negated when the invert flag is set.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = rs1.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - These cases are produced by the datapath itself, with no special-case logic.
- Stall rules:
  - `stall_o = (div_busy & (mul_op|div_op)) | (mul_inflight & div_op)`.
  - `mul_inflight` is the OR of all multiplier-stage valids.
  - These rules guarantee that two results can never collide on writeback.
- `flush_i`:
  - Synchronously clears every multiplier-stage valid.
  - Returns the divider to IDLE.
  - Suppresses any writeback loading on that same edge.
  - An opcode presented in the flush cycle is not accepted.

## Timing
- Reset: all outputs 0; divider IDLE; all pipeline valids 0.
- Multiply latency:
  - A multiply accepted at edge k loads the writeback registers at edge k+`MUL_STAGES`.
  - `writeback_valid_o` is therefore high during the cycle after that edge.
  - With `MUL_STAGES`=1 this is the legacy 2-cycle behaviour.
- Multiply throughput: one multiply per cycle, back-to-back, no stall.
- Divide latency:
  - A divide accepted at edge k runs its N = 32/`DIV_BITS_PER_CYCLE` iterations on edges k+1..k+N.
  - The writeback registers load at edge k+N+1.
  - `stall_o` stays asserted for muldiv opcodes from the cycle after acceptance through the completion cycle.
- `writeback_valid_o` is a one-cycle pulse per result.
- Reset asserted mid-operation clears all state immediately. No writeback occurs after reset is released.

## Configuration
- `MULDIV_DIV_ZERO_FAST_EN`
  - Defined: a divide with rs2 == 0 bypasses BUSY and loads writeback at edge k+1 with the architected result (quotient 0xFFFFFFFF, remainder = rs1). The divider stays IDLE and `stall_o` is never raised for that operation.
  - Undefined: divide by zero takes the full N+1-cycle path and returns the same values.

## Test plan
- Multiply corner cases, with `MUL_STAGES`=2 and rs1 = rs2 = 0xFFFFFFFF:
  - MUL returns 0x00000001.
  - MULH returns 0x00000000.
  - MULHU returns 0xFFFFFFFE.
  - MULHSU returns 0xFFFFFFFF.
  - Each result appears 2 edges after its issue.
- Back-to-back MUL: 7×6 to x5, then 3×3 to x6 on consecutive cycles -> writebacks (x5, 42) then (x6, 9) on consecutive cycles, with `stall_o` never high.
- Signed divide, with `DIV_BITS_PER_CYCLE`=2:
  - DIV −7/2 to x10 returns 0xFFFFFFFD with writeback at edge k+17.
  - REM −7/2 returns 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF returns 0x80000000.
- Divide by zero: DIVU 5/0 returns 0xFFFFFFFF and REM −5/0 returns 0xFFFFFFFB.
  - Latency is k+17 with the macro undefined and k+1 with it defined.
- Stall interaction: MUL issued, then DIV the next cycle -> DIV stalls until the MUL writes back.
  - A MUL issued during a divide stalls until the divide completes.
  - No cycle ever carries a double writeback.
- Flush and reset: `flush_i` at iteration 5 of a DIV -> no writeback, divider IDLE, the next DIV is accepted with no stall.
  - `rst_i` mid-MUL gives all outputs 0 and no stray writeback after release.
